// File: rtl/signed_seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the signed sequential divider.
interface signed_seq_divider_if #(parameter int N = 4);
    logic              start;
    logic [2*N-1:0]    dividend;
    logic [N-1:0]      divisor;
    logic              busy;
    logic              done;
    logic [2*N-1:0]    quotient;
    logic [N-1:0]      remainder;
    logic              div_by_zero;
    logic              overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_seq_divider.sv
// Signed restoring divider: 2N-bit dividend / N-bit divisor over 2N iteration cycles,
// magnitudes divided unsigned and signs applied in a final fix-up cycle.
module signed_seq_divider #(
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    signed_seq_divider_if.slave io_bus
);
    localparam int QW = 2 * N;
    localparam int CW = $clog2(QW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    r_state;
    logic [QW-1:0] r_quo;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_absDivisor;
    logic [CW-1:0] r_count;
    logic          r_signQ;
    logic          r_signR;
    logic          r_divZero;
    logic          r_ovf;
    logic [QW-1:0] r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_done;
    logic          r_divZeroOut;
    logic          r_ovfOut;

    logic [QW-1:0] w_absDividend;
    logic [N-1:0]  w_absDivisor;
    logic          w_isOvf;
    logic          w_isZero;
    logic [N:0]    w_shiftR;
    logic [N:0]    w_trial;
    logic [QW-1:0] w_negQ;
    logic [N-1:0]  w_negR;

    // The most negative values negate onto themselves, which reads correctly as an unsigned magnitude.
    assign w_absDividend = io_bus.dividend[QW-1] ? ({QW{1'b0}} - io_bus.dividend) : io_bus.dividend;
    assign w_absDivisor  = io_bus.divisor[N-1]   ? ({N{1'b0}} - io_bus.divisor)   : io_bus.divisor;
    assign w_isOvf       = (io_bus.dividend == {1'b1, {(QW-1){1'b0}}}) && (io_bus.divisor == {N{1'b1}});
    assign w_isZero      = (io_bus.divisor == {N{1'b0}});

    // The partial remainder stays below |divisor|, so the N+1 bit trial never wraps and bit N is its sign.
    assign w_shiftR = {r_rem, r_quo[QW-1]};
    assign w_trial  = w_shiftR - {1'b0, r_absDivisor};
    assign w_negQ   = {QW{1'b0}} - r_quo;
    assign w_negR   = {N{1'b0}} - r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_quo        <= '0;
            r_rem        <= '0;
            r_absDivisor <= '0;
            r_count      <= '0;
            r_signQ      <= 1'b0;
            r_signR      <= 1'b0;
            r_divZero    <= 1'b0;
            r_ovf        <= 1'b0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_done       <= 1'b0;
            r_divZeroOut <= 1'b0;
            r_ovfOut     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_quo        <= w_absDividend;
                        r_absDivisor <= w_absDivisor;
                        r_signQ      <= io_bus.dividend[QW-1] ^ io_bus.divisor[N-1];
                        r_signR      <= io_bus.dividend[QW-1];
                        r_rem        <= '0;
                        r_count      <= '0;
                        r_divZero    <= w_isZero;
                        r_ovf        <= w_isOvf;
                        r_state      <= w_isZero ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_trial[N]) begin
                        r_rem <= w_trial[N-1:0];
                        r_quo <= {r_quo[QW-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shiftR[N-1:0];
                        r_quo <= {r_quo[QW-2:0], 1'b0};
                    end
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(QW - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_done       <= 1'b1;
                    r_divZeroOut <= r_divZero;
                    r_ovfOut     <= r_ovf && !r_divZero;
                    if (r_divZero) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                    end else if (r_ovf) begin
                        r_quotient  <= {1'b1, {(QW-1){1'b0}}};
                        r_remainder <= '0;
                    end else begin
                        r_quotient  <= r_signQ ? w_negQ : r_quo;
                        r_remainder <= r_signR ? w_negR : r_rem;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.done        = r_done;
    assign io_bus.quotient    = r_quotient;
    assign io_bus.remainder   = r_remainder;
    assign io_bus.div_by_zero = r_divZeroOut;
    assign io_bus.overflow    = r_ovfOut;
endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed and exhaustive self-checking bench for the N=4 signed sequential divider.
module tb_signed_seq_divider;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    signed_seq_divider_if #(.N(N)) bus();

    signed_seq_divider #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and return the number of edges from acceptance to done, or -1 on timeout.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #22;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int busyCount;
        int doneCount;
        int doneEdge;
        @(negedge clk);
        bus.dividend = 8'h23;
        bus.divisor  = 4'h6;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busyCount = (bus.busy === 1'b1) ? 1 : 0;
        doneCount = 0;
        doneEdge  = -1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) busyCount++;
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneEdge < 0) doneEdge = e;
            end
        end
        checks++;
        if (doneEdge !== 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d edges, expected 9", doneEdge);
        end
        checks++;
        if (doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL basic_done_width: got %0d cycles, expected 1", doneCount);
        end
        checks++;
        if (busyCount !== 9) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, expected 9", busyCount);
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== {8'h05, 4'h5}) begin
            errors++;
            $display("[TB] FAIL basic_result: got q=%h r=%h, expected q=05 r=5", bus.quotient, bus.remainder);
        end
        checks++;
        if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_flags: got dz=%b ovf=%b, expected 0 0", bus.div_by_zero, bus.overflow);
        end
    endtask

    task automatic test_signs();
        logic [7:0] vecA [3] = '{8'hDD, 8'h23, 8'h80};
        logic [3:0] vecB [3] = '{4'h6, 4'h8, 4'h8};
        logic [7:0] expQ [3] = '{8'hFB, 8'hFC, 8'h10};
        logic [3:0] expR [3] = '{4'hB, 4'h3, 4'h0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(vecA[i], vecB[i], lat);
            checks++;
            if (lat !== 9 || {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {expQ[i], expR[i], 2'b00}) begin
                errors++;
                $display("[TB] FAIL signs_%0d: %h/%h got lat=%0d q=%h r=%h dz=%b ovf=%b, expected lat=9 q=%h r=%h dz=0 ovf=0",
                         i, vecA[i], vecB[i], lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, expQ[i], expR[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(8'h80, 4'hF, lat);
        checks++;
        if (bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_flags: got ovf=%b dz=%b, expected ovf=1 dz=0", bus.overflow, bus.div_by_zero);
        end
        checks++;
        if (lat !== 9 || {bus.quotient, bus.remainder} !== {8'h80, 4'h0}) begin
            errors++;
            $display("[TB] FAIL overflow_result: got lat=%0d q=%h r=%h, expected lat=9 q=80 r=0", lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(8'h07, 4'h0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL divzero_latency: got %0d edges, expected 1", lat);
        end
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {8'h00, 4'h0, 2'b10}) begin
            errors++;
            $display("[TB] FAIL divzero_result: got q=%h r=%h dz=%b ovf=%b, expected q=00 r=0 dz=1 ovf=0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        do_op(8'h0C, 4'h3, lat);
        checks++;
        if (lat !== 9 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {8'h04, 4'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL divzero_followup: got lat=%0d q=%h r=%h dz=%b, expected lat=9 q=04 r=0 dz=0",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus.dividend = 8'h23;
        bus.divisor  = 4'h6;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                bus.dividend = 8'h07;
                bus.divisor  = 4'h0;
                bus.start    = 1'b1;
            end else if (e == 4) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (lat !== 9 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {8'h05, 4'h5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ignore_start: got lat=%0d q=%h r=%h dz=%b, expected lat=9 q=05 r=5 dz=0",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_reset_mid();
        int sawDone;
        int lat;
        @(negedge clk);
        bus.dividend = 8'h23;
        bus.divisor  = 4'h6;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dz=%b ovf=%b, expected all zero",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone++;
        end
        checks++;
        if (sawDone !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_done: got %0d active cycles after reset, expected 0", sawDone);
        end
        do_op(8'h23, 4'h6, lat);
        checks++;
        if (lat !== 9 || {bus.quotient, bus.remainder} !== {8'h05, 4'h5}) begin
            errors++;
            $display("[TB] FAIL after_reset: got lat=%0d q=%h r=%h, expected lat=9 q=05 r=5", lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back();
        int firstDone;
        int secondDone;
        @(negedge clk);
        bus.dividend = 8'hDD;
        bus.divisor  = 4'h6;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        firstDone  = -1;
        secondDone = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (firstDone < 0) begin
                    firstDone = e;
                end else begin
                    secondDone = e;
                    bus.start  = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (firstDone !== 9 || secondDone !== 19) begin
            errors++;
            $display("[TB] FAIL back_to_back: got done at edges %0d and %0d, expected 9 and 19", firstDone, secondDone);
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== {8'hFB, 4'hB}) begin
            errors++;
            $display("[TB] FAIL back_to_back_result: got q=%h r=%h, expected q=FB r=B", bus.quotient, bus.remainder);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        int         lat;
        int         elat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        logic       eovf;
        int         qs;
        int         rs;
        int         absR;
        int         absB;
        for (int a = -128; a <= 127; a++) begin
            for (int b = -8; b <= 7; b++) begin
                do_op(8'(a), 4'(b), lat);
                if (b == 0) begin
                    eq = 8'h00; er = 4'h0; edz = 1'b1; eovf = 1'b0; elat = 1;
                end else begin
                    eq   = 8'(a / b);
                    er   = 4'(a % b);
                    edz  = 1'b0;
                    eovf = (a == -128 && b == -1);
                    elat = 9;
                end
                checks++;
                if (lat !== elat || {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {eq, er, edz, eovf}) begin
                    errors++;
                    $display("[TB] FAIL sweep %0d/%0d: got lat=%0d q=%h r=%h dz=%b ovf=%b, expected lat=%0d q=%h r=%h dz=%b ovf=%b",
                             a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, elat, eq, er, edz, eovf);
                end
                if (b != 0 && !eovf) begin
                    qs   = $signed(bus.quotient);
                    rs   = $signed(bus.remainder);
                    absR = (rs < 0) ? -rs : rs;
                    absB = (b < 0) ? -b : b;
                    checks++;
                    if (qs * b + rs != a || absR >= absB || (rs != 0 && ((rs < 0) != (a < 0)))) begin
                        errors++;
                        $display("[TB] FAIL sweep_identity %0d/%0d: got q=%0d r=%0d, expected q*d+r=dividend, |r|<|d|, sign(r)=sign(dividend)",
                                 a, b, qs, rs);
                    end
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Multi-cycle signed restoring divider: the inverse of the team's 4-bit Booth multiplier. It divides a 2N-bit two's-complement dividend (a product-width value) by an N-bit two's-complement divisor, producing a 2N-bit quotient and an N-bit remainder. It sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake.

## Interface
- N, default 4: divisor and remainder width. Dividend and quotient are 2N bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  signed dividend, sampled with start
- divisor  input  N  signed divisor, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the results become valid
- quotient  output  2N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder, same sign as the dividend (or zero)
- div_by_zero  output  1  divisor was 0 for the last operation
- overflow  output  1  quotient was not representable (most-negative dividend / -1)

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: 2N iteration cycles.
  - FIX: one cycle to apply signs and write the outputs.
- **IDLE, start=1:** latch the inputs.
  - Store |dividend| in 2N bits, unsigned; 2^(2N-1) must fit.
  - Store |divisor| in N bits, unsigned.
  - Store sign_q = dividend sign XOR divisor sign, and sign_r = dividend sign.
  - Clear the partial remainder R (N+1 bits) and set the iteration counter to 0.
  - If divisor == 0, go to FIX. Otherwise go to RUN.
- **RUN step:**
  - Shift {R, Q} left 1 bit.
  - Compute trial = R − |divisor|.
  - If trial ≥ 0: R = trial and Q[0] = 1. Otherwise Q[0] = 0.
  - Increment the counter. After step 2N, go to FIX.
- **FIX:** write the registered results, then go to IDLE.
  - quotient = sign_q ? −Q : Q.
  - remainder = sign_r ? −R[N-1:0] : R[N-1:0].
  - Divide by zero: quotient = 0, remainder = 0, div_by_zero = 1.
  - Overflow case (dividend = 100…0 and divisor = all ones): overflow = 1, quotient = 100…0 (wrapped value), remainder = 0.
  - div_by_zero and overflow are cleared in FIX for all other operations.
- start while busy is ignored. Inputs are only sampled at acceptance, so changing them mid-operation has no effect.
- Outputs (quotient, remainder and both flags) hold their values until the next FIX.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0.
  - Any in-flight operation is discarded; no done is produced for it.
- **Edge 0:** start is accepted in IDLE. busy = 1 from this edge.
- **Edges 1..2N:** RUN steps.
- **Edge 2N+1:** FIX.
  - Outputs are updated, done = 1 for exactly one cycle, busy = 0.
  - Latency from start to done is 2N+1 edges (9 for N=4).
- Divide by zero: FIX occurs at edge 1, so done appears 1 edge after acceptance.
- Back-to-back operation: start may be high in the same cycle that done is high. State is IDLE at that point, so it is accepted at the next edge.
- Continuous start = 1 gives one operation every 2N+2 cycles.

## Test plan
- N=4, 35 / 6 (8'h23, 4'h6) -> quotient 8'h05, remainder 4'h5. done exactly 9 edges after start, one cycle wide. busy high for 9 cycles.
- Sign combinations:
  - −35 / 6 (8'hDD) -> quotient 8'hFB, remainder 4'hB.
  - 35 / −8 (4'h8) -> quotient 8'hFC, remainder 4'h3.
  - −128 / −8 -> quotient 8'h10, remainder 4'h0.
- −128 / −1 (8'h80, 4'hF) -> overflow = 1, quotient 8'h80, remainder 0, div_by_zero = 0.
- 7 / 0 -> div_by_zero = 1, quotient 0, remainder 0, done 1 edge after start.
  - A following 12 / 3 -> quotient 4, remainder 0, div_by_zero = 0.
- Handshake and reset:
  - Pulse start (with different operands) mid-RUN -> ignored; first result correct.
  - Assert rst_n = 0 at RUN step 3 -> all outputs 0 immediately, no done.
  - After release, a new 35 / 6 completes correctly.
- Exhaustive sweep over all dividend in [−128, 127] × divisor in [−8, 7] against a reference model:
  - divisor 0 -> div_by_zero.
  - Otherwise quotient*divisor + remainder == dividend.
  - |remainder| < |divisor|.
  - remainder sign matches dividend (or remainder is zero).
